sr_flag_arbiter: RTL
====================

# sr_flag_arbiter

Round-robin controller that shares a bank of SR-style status flags between several requesters. Each requester asks to set or clear one flag. The block serialises these requests and drives one-hot set/reset strobes into its internal flag bank. It guarantees that no flag ever sees s=1 and r=1 together, which is the invalid SR condition. It sits between the requesting agents and the status/flag register, replacing ad-hoc s/r gating at each agent.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFLAG, 6, number of flags in the bank (1..2^IW)
- IW, 3, flag index width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request; held high until its ack
- op  input  NREQ  per-requester operation: 1 = set, 0 = clear
- idx  input  NREQ*IW  per-requester flag index; requester k uses bits [k*IW +: IW]
- ack  output  NREQ  one-cycle completion pulse to the granted requester
- err  output  1  one-cycle pulse, coincident with ack, when the granted idx >= NFLAG
- flags  output  NFLAG  current flag bank state (registered)
- s_bus  output  NFLAG  set strobes into the bank; one-hot or zero
- r_bus  output  NFLAG  reset strobes into the bank; one-hot or zero
- busy  output  1  high in APPLY and ACK states

## Operation
- FSM has three states: IDLE, APPLY, ACK.
- IDLE:
  - If any req bit is high at the edge, pick the winner by round-robin. The search starts at ptr and goes ptr, ptr+1, ... wrapping mod NREQ; the first requester with req=1 wins.
  - On that edge, latch the winner id, op[winner] and idx[winner]. Go to APPLY.
  - If no req bit is high, stay in IDLE.
- APPLY:
  - If the latched idx < NFLAG: drive s_bus[idx]=op and r_bus[idx]=~op. All other bits are 0.
  - If the latched idx >= NFLAG: s_bus and r_bus stay 0.
  - At the edge, the flag bank applies SR semantics: s -> 1, r -> 0, neither -> hold. Go to ACK.
- ACK:
  - ack[winner]=1. err=1 if the latched idx >= NFLAG.
  - At the edge: ptr <= (winner+1) mod NREQ; go to IDLE.
- Requester rule: deassert req on the edge that samples ack=1.
  - req is not sampled in APPLY or ACK.
  - req and op/idx changes during APPLY/ACK have no effect, because the captured values are used.
- Setting an already-set flag, or clearing an already-clear flag, still completes normally with ack and no change to flags.
- Invariant: (s_bus & r_bus) == 0 at all times, and popcount(s_bus | r_bus) <= 1.
- Reset values (rst high at any edge has priority over all other behaviour):
  - Next state is IDLE.
  - ptr=0, flags=0, ack=0, err=0, s_bus=0, r_bus=0, busy=0.
- Reset mid-operation: an in-flight request is dropped.
  - No flag update occurs, even if rst is sampled on the APPLY edge.
  - No ack is issued.
  - The requester must reissue after reset.

## Timing
- Cycle N: req[k] high in IDLE, sampled at the end-of-N edge.
- Cycle N+1: APPLY; s_bus/r_bus valid; busy=1.
- Cycle N+2: ACK; flags shows the new value; ack[k]=1; busy=1.
- Cycle N+3: IDLE. The earliest next grant is sampled at the end of N+3.
- Throughput: one operation per 3 cycles.
- Worst-case wait for a continuously requesting agent: (NREQ-1)*3 cycles plus its own 3.
- Simultaneous requests in the same cycle: the one nearest ptr wins; the others wait, still holding req.
- All outputs are registered or decoded from registered state. There is no combinational path from req/op/idx to any output.

## Test plan
- Reset with all req=1 -> flags=0, ack=0, busy=0. The first grant goes to requester 0 after rst falls.
- Single request: req[2]=1, op=1, idx=4 in IDLE.
  - Next cycle: s_bus=6'b010000, r_bus=0.
  - Cycle after: flags[4]=1, ack=4'b0100, err=0.
  - Cycle after that: busy=0.
- Simultaneous req[0..3]=1 from ptr=0 with distinct idx -> acks arrive in order 0,1,2,3, three cycles apart. With req[0] re-raised it then wins again after 3.
- Conflict on flag 1: requester 1 sets and requester 3 clears, both raised together at ptr=0 -> set is applied first, then clear; final flags[1]=0. s_bus and r_bus are never both high on bit 1.
- Out-of-range: req[1]=1, idx=7 -> s_bus=r_bus=0 in APPLY; ack[1]=1 with err=1; flags unchanged.
- rst asserted during APPLY of a set to flag 2 -> flags[2] stays 0, no ack, state IDLE, ptr=0. Throughout all tests, a monitor checks (s_bus & r_bus)==0.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises set/clear requests from NREQ agents onto a
// bank of SR flags, driving one-hot set/reset strobes so s and r never collide.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 6,
    parameter int IW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IW-1:0]   idx,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [NFLAG-1:0]     flags,
    output logic [NFLAG-1:0]     s_bus,
    output logic [NFLAG-1:0]     r_bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    // Handshake: a requester holds req (with stable op/idx) high until it sees
    // ack for one cycle; it drops req on the edge that samples ack. Only IDLE samples req.

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_id;
    logic [IW-1:0]   idx_l;

    logic            found;
    logic [PW-1:0]   win_next;
    logic            sel_op;
    logic [IW-1:0]   sel_idx;
    logic            sel_in_range;
    logic [NFLAG-1:0] sel_onehot;
    int              cand;

    assign state_dbg = state;

    // First requester at or after ptr, wrapping, wins.
    always_comb begin
        found    = 1'b0;
        win_next = '0;
        sel_op   = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!found && req[cand]) begin
                found    = 1'b1;
                win_next = PW'(cand);
                sel_op   = op[cand];
                sel_idx  = idx[cand*IW +: IW];
            end
        end
    end

    assign sel_in_range = (int'(sel_idx) < NFLAG);
    assign sel_onehot   = sel_in_range ? (NFLAG'(1) << sel_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            win_id <= '0;
            idx_l  <= '0;
            flags  <= '0;
            ack    <= '0;
            err    <= 1'b0;
            s_bus  <= '0;
            r_bus  <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win_id <= win_next;
                        idx_l  <= sel_idx;
                        s_bus  <= sel_op ? sel_onehot : '0;
                        r_bus  <= sel_op ? '0 : sel_onehot;
                        busy   <= 1'b1;
                        state  <= APPLY;
                    end
                end
                APPLY: begin
                    // Strobes are one-hot and mutually exclusive, so this is plain SR behaviour.
                    flags <= (flags | s_bus) & ~r_bus;
                    s_bus <= '0;
                    r_bus <= '0;
                    ack   <= NREQ'(1) << win_id;
                    err   <= (int'(idx_l) >= NFLAG);
                    state <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    ptr   <= (int'(win_id) == NREQ - 1) ? '0 : win_id + PW'(1);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
